// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants, coordinate type and sync bundle
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    // Half-open window test lo <= v < hi on a coordinate
    function automatic logic in_window(input coord_t v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - enabled shift register with async reset value; DEPTH 0 is a wire
module vga_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_q = i_d;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else if (i_en) begin
                    r_stage[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_q = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, pixel clock and delayed hs/vs/blank
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE  = DEF_H_VISIBLE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_VISIBLE  = DEF_V_VISIBLE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter int PIPE_DELAY = 2
) (
    input  logic   Clk,
    input  logic   Reset,
    output logic   vga_clk,
    output logic   hs,
    output logic   vs,
    output logic   blank,
    output logic   sync,
    output coord_t DrawX,
    output coord_t DrawY,
    output logic   frame_start,
    output logic   line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO   = H_VISIBLE + H_FRONT;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_VISIBLE + V_FRONT;
    localparam int VS_HI   = VS_LO + V_SYNC;

    logic   r_phase;
    coord_t r_hc;
    coord_t r_vc;
    logic   r_line_start;
    logic   r_frame_start;

    logic   w_pix_en;
    logic   w_h_wrap;
    coord_t w_hc_next;
    coord_t w_vc_next;
    sync_t  w_raw;
    sync_t  w_dly;

    // Counters advance on the edge where vga_clk falls, giving consumers half a pixel of setup
    assign w_pix_en = r_phase;

    always_comb begin
        w_h_wrap  = (r_hc == coord_t'(H_TOTAL - 1));
        w_hc_next = w_h_wrap ? '0 : r_hc + 1'b1;
        w_vc_next = r_vc;
        if (w_h_wrap) begin
            w_vc_next = (r_vc == coord_t'(V_TOTAL - 1)) ? '0 : r_vc + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_phase       <= 1'b0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_phase       <= ~r_phase;
            r_line_start  <= w_pix_en && w_h_wrap;
            r_frame_start <= w_pix_en && w_h_wrap && (w_vc_next == '0);
            if (w_pix_en) begin
                r_hc <= w_hc_next;
                r_vc <= w_vc_next;
            end
        end
    end

    always_comb begin
        w_raw       = SYNC_IDLE;
        w_raw.hs    = !in_window(r_hc, HS_LO, HS_HI);
        w_raw.vs    = !in_window(r_vc, VS_LO, VS_HI);
        w_raw.blank = in_window(r_hc, 0, H_VISIBLE) && in_window(r_vc, 0, V_VISIBLE);
    end

    vga_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .WIDTH   ($bits(sync_t)),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .i_clk (Clk),
        .i_rst (Reset),
        .i_en  (w_pix_en),
        .i_d   (w_raw),
        .o_q   (w_dly)
    );

    assign vga_clk     = r_phase;
    assign hs          = w_dly.hs;
    assign vs          = w_dly.vs;
    assign blank       = w_dly.blank;
    assign sync        = 1'b0;
    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen at default, zero-delay and tiny timings
module tb_vga_timing_gen;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n       = 0;
    int cnt_en  = 1;
    int t_fs_cnt = 0, t_vs_cnt = 0, t_b_cnt = 0, d_b_cnt = 0, d_hs_cnt = 0;

    logic       d_vclk, d_hs, d_vs, d_b, d_sync, d_fs, d_ls;
    logic [9:0] d_x, d_y;
    logic       z_vclk, z_hs, z_vs, z_b, z_sync, z_fs, z_ls;
    logic [9:0] z_x, z_y;
    logic       t_vclk, t_hs, t_vs, t_b, t_sync, t_fs, t_ls;
    logic [9:0] t_x, t_y;

    vga_timing_gen u_def (
        .Clk(Clk), .Reset(Reset), .vga_clk(d_vclk), .hs(d_hs), .vs(d_vs), .blank(d_b),
        .sync(d_sync), .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs), .line_start(d_ls)
    );

    vga_timing_gen #(.PIPE_DELAY(0)) u_pd0 (
        .Clk(Clk), .Reset(Reset), .vga_clk(z_vclk), .hs(z_hs), .vs(z_vs), .blank(z_b),
        .sync(z_sync), .DrawX(z_x), .DrawY(z_y), .frame_start(z_fs), .line_start(z_ls)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIPE_DELAY(2)
    ) u_tiny (
        .Clk(Clk), .Reset(Reset), .vga_clk(t_vclk), .hs(t_hs), .vs(t_vs), .blank(t_b),
        .sync(t_sync), .DrawX(t_x), .DrawY(t_y), .frame_start(t_fs), .line_start(t_ls)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs at negedge n after reset release: n Clk edges give n/2 pixel steps
    task automatic chk_inst(input string tag, input int hv, input int hf, input int hsw, input int hb,
                            input int vv, input int vf, input int vsw, input int vb, input int dly,
                            input logic vclk, input logic [9:0] x, input logic [9:0] y,
                            input logic h, input logic v, input logic b, input logic s,
                            input logic ls, input logic fs);
        int ht, vt, p, q, qx, qy, ex, ey;
        logic eh, ev, eb, els, efs;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = n / 2;
        ex = p % ht;
        ey = (p / ht) % vt;
        eh = 1'b1; ev = 1'b1; eb = 1'b0;
        if (p >= dly) begin
            q  = p - dly;
            qx = q % ht;
            qy = (q / ht) % vt;
            eh = !(qx >= hv + hf && qx < hv + hf + hsw);
            ev = !(qy >= vv + vf && qy < vv + vf + vsw);
            eb = (qx < hv) && (qy < vv);
        end
        els = (n % 2 == 0) && (n > 0) && (ex == 0);
        efs = els && (ey == 0);
        chk({tag, "_vga_clk"}, vclk, n % 2);
        chk({tag, "_DrawX"}, x, ex);
        chk({tag, "_DrawY"}, y, ey);
        chk({tag, "_hs"}, h, eh);
        chk({tag, "_vs"}, v, ev);
        chk({tag, "_blank"}, b, eb);
        chk({tag, "_sync"}, s, 0);
        chk({tag, "_line_start"}, ls, els);
        chk({tag, "_frame_start"}, fs, efs);
    endtask

    task automatic check_all();
        chk_inst("def", 640, 16, 96, 48, 480, 10, 2, 33, 2,
                 d_vclk, d_x, d_y, d_hs, d_vs, d_b, d_sync, d_ls, d_fs);
        chk_inst("pd0", 640, 16, 96, 48, 480, 10, 2, 33, 0,
                 z_vclk, z_x, z_y, z_hs, z_vs, z_b, z_sync, z_ls, z_fs);
        chk_inst("tiny", 4, 1, 1, 1, 3, 1, 1, 1, 2,
                 t_vclk, t_x, t_y, t_hs, t_vs, t_b, t_sync, t_ls, t_fs);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_def_x"}, d_x, 0);
        chk({tag, "_def_y"}, d_y, 0);
        chk({tag, "_def_hs"}, d_hs, 1);
        chk({tag, "_def_vs"}, d_vs, 1);
        chk({tag, "_def_blank"}, d_b, 0);
        chk({tag, "_def_vga_clk"}, d_vclk, 0);
        chk({tag, "_def_ls"}, d_ls, 0);
        chk({tag, "_def_fs"}, d_fs, 0);
        chk({tag, "_tiny_x"}, t_x, 0);
        chk({tag, "_tiny_blank"}, t_b, 0);
        chk({tag, "_tiny_ls"}, t_ls, 0);
        chk({tag, "_tiny_fs"}, t_fs, 0);
    endtask

    task automatic step();
        @(posedge Clk);
        n++;
        @(negedge Clk);
        check_all();
    endtask

    task automatic run_to(input int last);
        while (n < last) begin
            step();
            if (cnt_en != 0 && n <= 252) begin
                if (t_fs) t_fs_cnt++;
                if (n % 2 == 0 && !t_vs) t_vs_cnt++;
                if (n % 2 == 0 && t_b) t_b_cnt++;
            end
            if (cnt_en != 0 && n <= 1600 && n % 2 == 0) begin
                if (d_b) d_b_cnt++;
                if (!d_hs) d_hs_cnt++;
            end
            case (n)
                12:   begin chk("tiny_x6", t_x, 6); chk("tiny_hs_pre", t_hs, 1); end
                14:   begin chk("tiny_wrap_x", t_x, 0); chk("tiny_wrap_y", t_y, 1);
                            chk("tiny_ls", t_ls, 1); chk("tiny_hs_low", t_hs, 0); end
                84:   begin chk("tiny_frame_x", t_x, 0); chk("tiny_frame_y", t_y, 0);
                            chk("tiny_fs", t_fs, 1); end
                1278: begin chk("pd0_blank_639", z_b, 1); chk("def_blank_639", d_b, 1); end
                1280: chk("pd0_blank_640", z_b, 0);
                1282: chk("def_blank_641", d_b, 1);
                1284: chk("def_blank_642", d_b, 0);
                1310: chk("pd0_hs_655", z_hs, 1);
                1312: begin chk("pd0_hs_656", z_hs, 0); chk("def_hs_656", d_hs, 1); end
                1314: chk("def_hs_657", d_hs, 1);
                1316: begin chk("def_hs_658", d_hs, 0); chk("def_x_658", d_x, 658); end
                1506: chk("def_hs_753", d_hs, 0);
                1508: chk("def_hs_754", d_hs, 1);
                1598: begin chk("def_x_799", d_x, 799); chk("def_y_799", d_y, 0); end
                1600: begin chk("def_wrap_x", d_x, 0); chk("def_wrap_y", d_y, 1);
                            chk("def_wrap_ls", d_ls, 1); chk("def_wrap_fs", d_fs, 0); end
                1601: begin chk("def_ls_drop", d_ls, 0); chk("def_x_hold", d_x, 0); end
                default: ;
            endcase
        end
    endtask

    initial begin
        Reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk_reset_vals("por");
        end
        Reset = 1'b0;
        n = 0;
        check_all();
        run_to(2200);
        cnt_en = 0;
        chk("tiny_fs_count", t_fs_cnt, 3);
        chk("tiny_vs_low_pixels", t_vs_cnt, 21);
        chk("tiny_blank_pixels", t_b_cnt, 36);
        chk("def_line0_blank_pixels", d_b_cnt, 640);
        chk("def_line0_hs_low_pixels", d_hs_cnt, 96);
        chk("mid_x", d_x, 300);
        chk("mid_y", d_y, 1);

        #2 Reset = 1'b1;
        #1 chk_reset_vals("async");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk_reset_vals("hold");
        end
        Reset = 1'b0;
        n = 0;
        check_all();
        run_to(1700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
